// File: rtl/dvga_mem_arbiter.sv
// Two-master Wishbone arbiter: fixed priority to the display DMA (m0), no preemption,
// plus a master-0 wait monitor with sticky starvation flag and worst-case wait capture.
module dvga_mem_arbiter #(
  parameter int WAIT_LIMIT = 32,
  parameter int WCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic [31:0]       m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        gnt_o,
  output logic              starve_o,
  output logic [WCNT_W-1:0] max_wait_o,
  input  logic              clr_i
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    gnt_o     = 2'b00;
    case (state)
      IDLE: begin
        if (m0_cyc_i)      state_nxt = G0;
        else if (m1_cyc_i) state_nxt = G1;
      end
      G0: begin
        gnt_o = 2'b01;
        if (!m0_cyc_i) state_nxt = IDLE;
      end
      G1: begin
        gnt_o = 2'b10;
        if (!m1_cyc_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Forward path follows the registered grant; IDLE parks the slave bus at zero.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (state == G0) begin
      s_adr_o = m0_adr_i;  s_dat_o = m0_dat_i;  s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;   s_stb_o = m0_stb_i;  s_cyc_o = m0_cyc_i;
      s_cti_o = m0_cti_i;  s_bte_o = m0_bte_i;
    end else if (state == G1) begin
      s_adr_o = m1_adr_i;  s_dat_o = m1_dat_i;  s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;   s_stb_o = m1_stb_i;  s_cyc_o = m1_cyc_i;
      s_cti_o = m1_cti_i;  s_bte_o = m1_bte_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == G0) & s_ack_i;
  assign m0_err_o = (state == G0) & s_err_i;
  assign m0_rty_o = (state == G0) & s_rty_i;
  assign m1_ack_o = (state == G1) & s_ack_i;
  assign m1_err_o = (state == G1) & s_err_i;
  assign m1_rty_o = (state == G1) & s_rty_i;

  always_comb begin
    wcnt_nxt = '0;
    if (m0_cyc_i && state != G0)
      wcnt_nxt = (wcnt == '1) ? wcnt : wcnt + 1'b1;
  end

  // Starvation is judged on the value the counter is about to take, so the flag
  // rises together with the counter crossing the limit.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wcnt       <= '0;
      max_wait_o <= '0;
      starve_o   <= 1'b0;
    end else begin
      wcnt <= wcnt_nxt;
      if (wcnt > max_wait_o) max_wait_o <= wcnt;
      if (int'(wcnt_nxt) > WAIT_LIMIT) starve_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dvga_mem_arbiter.sv
// Directed bench for dvga_mem_arbiter: grant order, routing, no-preemption bursts,
// starvation flag, wait saturation and mid-burst reset.
module tb_dvga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  gnt;
  logic        starve, clr, ack_en;
  logic [7:0]  max_wait;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Slave model: zero-wait acknowledge of every strobed beat when enabled.
  assign s_ack = ack_en & s_cyc & s_stb;

  dvga_mem_arbiter #(.WAIT_LIMIT(32), .WCNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt), .starve_o(starve), .max_wait_o(max_wait), .clr_i(clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ack_en = 1'b0;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_cti = '0; m0_bte = '0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_cti = '0; m1_bte = '0;
    s_rdat = '0; s_err = 0; s_rty = 0;
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_scyc", s_cyc, 0);
    check("rst_sstb", s_stb, 0);
    check("rst_starve", starve, 0);
    check("rst_maxw", max_wait, 0);
    rst = 1'b0;

    // Single m0 read
    m0_adr = 32'h0000_1000; m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF;
    m1_adr = 32'h5555_0000;
    tick();
    check("rd_gnt", gnt, 2'b01);
    check("rd_sadr", s_adr, 32'h0000_1000);
    check("rd_scyc", s_cyc, 1);
    check("rd_ack_early", m0_ack, 0);
    s_rdat = 32'hDEAD_BEEF; ack_en = 1; #1;
    check("rd_dat", m0_rdat, 32'hDEAD_BEEF);
    check("rd_m0ack", m0_ack, 1);
    check("rd_m1ack", m1_ack, 0);
    tick();
    m0_cyc = 0; m0_stb = 0; ack_en = 0;
    tick();
    check("idle_gnt", gnt, 0);
    check("idle_sadr", s_adr, 0);

    // Simultaneous request: m0 wins, one idle cycle, then m1
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; ack_en = 1;
    tick();
    check("sim_gnt0", gnt, 2'b01);
    check("sim_m1ack", m1_ack, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    check("sim_idle", gnt, 2'b00);
    tick();
    check("sim_gnt1", gnt, 2'b10);
    check("sim_sadr", s_adr, 32'h5555_0000);
    s_err = 1; #1;
    check("err_m1", m1_err, 1);
    check("err_m0", m0_err, 0);
    tick();
    check("err_keep_gnt", gnt, 2'b10);
    s_err = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // No preemption: 8-beat incrementing m1 burst, m0 requests at beat 2
    m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; ack_en = 1;
    tick();
    for (int b = 0; b < 8; b++) begin
      check($sformatf("burst_ack%0d", b), m1_ack, 1);
      check($sformatf("burst_gnt%0d", b), gnt, 2'b10);
      if (b == 7) check("burst_last_cti", s_cti, 3'b111);
      if (b == 1) m0_cyc = 1;
      if (b == 6) m1_cti = 3'b111;
      if (b == 7) begin m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000; end
      tick();
    end
    check("burst_idle", gnt, 2'b00);
    tick();
    check("burst_m0_gnt", gnt, 2'b01);
    m0_cyc = 0; ack_en = 0;
    tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr0_maxw", max_wait, 0);

    // Starvation: m0 waits 40 cycles behind m1
    m1_cyc = 1; m1_stb = 1;
    tick();
    check("stv_gnt1", gnt, 2'b10);
    m0_cyc = 1; m0_stb = 1;
    for (int i = 1; i <= 38; i++) begin
      tick();
      if (i == 32) check("stv_at32", starve, 0);
      if (i == 33) check("stv_at33", starve, 1);
    end
    m1_cyc = 0; m1_stb = 0;
    tick();
    check("stv_idle", gnt, 2'b00);
    tick();
    check("stv_gnt0", gnt, 2'b01);
    tick();
    check("stv_maxw", max_wait, 40);
    check("stv_sticky", starve, 1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr_starve", starve, 0);
    check("clr_maxw", max_wait, 0);

    // Saturation: m0 waits 300 cycles
    m1_cyc = 1; m1_stb = 1;
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 298; i++) tick();
    m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    check("sat_gnt0", gnt, 2'b01);
    tick();
    check("sat_maxw", max_wait, 255);
    tick();
    check("sat_hold", max_wait, 255);
    m0_cyc = 0; m0_stb = 0;
    tick();

    // Reset mid-burst
    m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; ack_en = 1;
    tick();
    check("rb_gnt1", gnt, 2'b10);
    check("rb_ack", m1_ack, 1);
    rst = 1;
    tick();
    check("rb_gnt", gnt, 2'b00);
    check("rb_scyc", s_cyc, 0);
    check("rb_m1ack", m1_ack, 0);
    check("rb_starve", starve, 0);
    rst = 0; m1_cyc = 0; m1_stb = 0; ack_en = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
